// File: rtl/k2red_pkg.sv
// Shared types and constants for the K2-RED output scaler.
// State encoding, default datapath width and the iteration counter width helper.
package k2red_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} k2_state_t;

  localparam int K2_W = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/k2red_scale_step.sv
// One MSB-first shift-add-reduce iteration: P' = (2P + b*C) mod Q, given P < Q and C < Q.
// Purely combinational; no handshake, so it never stalls.
module k2red_scale_step
  import k2red_pkg::*;
#(
  parameter int W = K2_W
) (
  input  logic [W+1:0] p,
  input  logic         b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] q,
  output logic [W+1:0] p_next
);

  logic [W+1:0] addend;
  logic [W+1:0] t;
  logic [W+1:0] q1;
  logic [W+1:0] q2;

  // With P < Q and C < Q, T < 3Q, so one of two subtractions always lands below Q.
  always_comb begin
    addend = b ? {2'b00, c} : '0;
    t      = (p << 1) + addend;
    q1     = {2'b00, q};
    q2     = {1'b0, q, 1'b0};
    p_next = t;
    if (t >= q2) begin
      p_next = t - q2;
    end else if (t >= q1) begin
      p_next = t - q1;
    end
  end

endmodule

// File: rtl/k2red_scale.sv
// Bit-serial scaler Y = C*S mod Q leaving the K2-RED domain; result W+1 cycles after acceptance.
// One operand set in flight; out_ready low in DONE holds Y and out_valid indefinitely.
module k2red_scale
  import k2red_pkg::*;
#(
  parameter int W = K2_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] C,
  input  logic [W-1:0] S,
  input  logic [W-1:0] Q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Y,
  output logic         busy
);

  localparam int IW = cnt_width(W);

  k2_state_t     state;
  k2_state_t     state_nx;
  logic [W-1:0]  c_reg;
  logic [W-1:0]  s_reg;
  logic [W-1:0]  q_reg;
  logic [W+1:0]  p_reg;
  logic [W+1:0]  p_next;
  logic [IW-1:0] i_cnt;
  logic [IW-1:0] bit_idx;
  logic          last_iter;

  assign in_ready  = rst && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // i_cnt counts iterations upward; S is consumed from its MSB.
  assign bit_idx   = IW'(W - 1) - i_cnt;
  assign last_iter = (i_cnt == IW'(W - 1));

  k2red_scale_step #(.W(W)) u_step (
    .p      (p_reg),
    .b      (s_reg[bit_idx]),
    .c      (c_reg),
    .q      (q_reg),
    .p_next (p_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = LOAD;
      LOAD:    state_nx = MUL;
      MUL:     if (last_iter) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_reg <= '0;
      s_reg <= '0;
      q_reg <= '0;
      p_reg <= '0;
      i_cnt <= '0;
      Y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_reg <= C;
            s_reg <= S;
            q_reg <= Q;
          end
        end
        LOAD: begin
          // C arrives below 2Q; one subtraction brings it under Q for the step invariant.
          if (c_reg >= q_reg) begin
            c_reg <= c_reg - q_reg;
          end
          p_reg <= '0;
          i_cnt <= '0;
        end
        MUL: begin
          p_reg <= p_next;
          i_cnt <= i_cnt + 1'b1;
          if (last_iter) begin
            Y <= p_next[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_k2red_scale.sv
// Scoreboarded bench for k2red_scale: directed corner cases, backpressure, mid-run reset, random traffic.
module tb_k2red_scale;
  import k2red_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] C;
  logic [W-1:0] S;
  logic [W-1:0] Q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic         busy;

  k2red_scale #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C         (C),
    .S         (S),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .busy      (busy)
  );

  int vectors;
  int miscompares;
  int cyc;
  int n_push;
  int n_pop;
  logic [W-1:0] sb[$];
  bit   rand_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] c, input logic [W-1:0] s,
                                         input logic [W-1:0] q);
    logic [63:0] pr;
    pr = 64'(c) * 64'(s);
    return 32'(pr % 64'(q));
  endfunction

  // Monitor: samples on the falling edge, inputs change 2 units after the rising edge.
  int          acc_cyc;
  int          last_acc;
  bit          have_prev;
  bit          prev_ov;
  bit          prev_hs;
  logic [W-1:0] prev_y;

  always @(negedge clk) begin
    if (!rst) begin
      have_prev = 1'b0;
      prev_ov   = 1'b0;
      prev_hs   = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (have_prev) chk("issue_interval_ge35", 64'((cyc + 1 - last_acc) >= 35), 64'd1);
        last_acc  = cyc + 1;
        acc_cyc   = cyc + 1;
        have_prev = 1'b1;
        sb.push_back(model(C, S, Q));
        n_push++;
      end
      if (prev_ov && !prev_hs) begin
        chk("ov_held", 64'(out_valid), 64'd1);
        chk("y_held", 64'(Y), 64'(prev_y));
      end
      if (out_valid && !prev_ov) chk("latency", 64'(cyc - acc_cyc), 64'd33);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 64'd1, 64'd0);
        end else begin
          chk("Y", 64'(Y), 64'(sb.pop_front()));
        end
        n_pop++;
      end
      prev_ov = out_valid;
      prev_hs = out_valid && out_ready;
      prev_y  = Y;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] c, input logic [W-1:0] s, input logic [W-1:0] q);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    C = c;
    S = s;
    Q = q;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (n_pop == n_push) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("result_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [W-1:0] rq, rs, rc;
    bit ok;
    vectors = 0; miscompares = 0; cyc = 0; n_push = 0; n_pop = 0;
    rand_rdy = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    C = '0; S = '0; Q = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_Y", 64'(Y), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    send(32'd1125, 32'd990, 32'd7681);
    wait_done();
    chk("k15_result", 64'(Y), 64'd5);
    send(32'h7FFF_FFFE, 32'h7FFF_FFFE, 32'h7FFF_FFFF);
    wait_done();
    chk("mersenne_result", 64'(Y), 64'd1);
    send(32'd0, 32'd990, 32'd7681);
    wait_done();
    send(32'd7680, 32'd1, 32'd7681);
    wait_done();
    send(32'd7681 + 32'd1125, 32'd990, 32'd7681);
    wait_done();
    chk("norm_result", 64'(Y), 64'd5);
    send(32'd1234, 32'd0, 32'd7681);
    wait_done();

    // Backpressure: hold the result 10 cycles while in_valid pulses are offered.
    @(posedge clk); #2;
    out_ready = 1'b0;
    send(32'd4321, 32'd999, 32'd7681);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_valid_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      in_valid = k[0];
      C = 32'(k + 7); S = 32'd3; Q = 32'd11;
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_Y", 64'(Y), 64'(model(32'd4321, 32'd999, 32'd7681)));
    end
    out_ready = 1'b1;
    send(32'd5000, 32'd6000, 32'd7681);
    wait_done();

    // Reset in the middle of MUL aborts the run with nothing presented.
    send(32'd77, 32'd88, 32'd101);
    repeat (16) @(posedge clk);
    #2;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_Y", 64'(Y), 64'd0);
    sb.delete();
    n_pop = n_push;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    send(32'd1125, 32'd990, 32'd7681);
    wait_done();
    chk("post_rst_result", 64'(Y), 64'd5);

    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rq = (32'($urandom_range(1, 32'h3FFF_FFFF)) << 1) | 32'd1;
      rs = $urandom % rq;
      rc = 32'(64'($urandom) % (64'(rq) * 64'd2));
      send(rc, rs, rq);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_done();
    rand_rdy = 1'b0;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
